// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bus round-robin arbiter.
package reg_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   localparam int NREQ_MAX = 8;

   function automatic int grant_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/reg_arb_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from (last+1) mod NREQ with wrap-around.
module reg_arb_rr_pick import reg_arb_pkg::*; #(
   parameter  int NREQ = 4,
   localparam int GW   = grant_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   last,
   output logic            found,
   output logic [GW-1:0]   win
);

   // Scan offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      logic [GW-1:0] idx_v;
      found = 1'b0;
      win   = '0;
      idx_v = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx_v = GW'((int'(last) + k) % NREQ);
         found = found | req[idx_v];
         win   = req[idx_v] ? idx_v : win;
      end
   end

endmodule

// File: rtl/reg_bus_arb.sv
// Round-robin arbiter sharing one register-bus initiator port among NREQ requesters.
// Optional timeout logging is enabled by defining REG_ARB_ERR_LOG_EN.
module reg_bus_arb import reg_arb_pkg::*; #(
   parameter  int NREQ = 4,
   parameter  int AW   = 26,
   parameter  int DW   = 32,
   parameter  int BEW  = 4,
   localparam int GW   = grant_w(NREQ)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NREQ-1:0]   req_cs,
   input  logic [NREQ*AW-1:0]  req_addr,
   input  logic [NREQ*DW-1:0]  req_wdata,
   input  logic [NREQ-1:0]   req_wr,
   input  logic [NREQ*BEW-1:0] req_be,
   output logic [DW-1:0]     req_rdata,
   output logic [NREQ-1:0]   req_ack,
   output logic [NREQ-1:0]   req_timeout,
   output logic              m_reg_cs,
   output logic [AW-1:0]     m_reg_addr,
   output logic [DW-1:0]     m_reg_wdata,
   output logic              m_reg_wr,
   output logic [BEW-1:0]    m_reg_be,
   input  logic [DW-1:0]     m_reg_rdata,
   input  logic              m_reg_ack,
   input  logic              m_reg_timeout,
   output logic [GW-1:0]     grant_id,
   output logic              err_valid,
   output logic [GW-1:0]     err_id,
   output logic [AW-1:0]     err_addr,
   input  logic              err_clr
);

   arb_state_e     state_r;
   logic [GW-1:0]  grant_id_r;
   logic [GW-1:0]  last_r;
   logic           m_reg_cs_r;
   logic           found_s;
   logic [GW-1:0]  win_s;
   logic           ack_hit_s;
   logic [AW-1:0]  m_reg_addr_s;
   logic [NREQ-1:0] req_ack_s;
   logic [NREQ-1:0] req_timeout_s;

   reg_arb_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req_cs),
      .last  (last_r),
      .found (found_s),
      .win   (win_s)
   );

   // Arbitration FSM; RELEASE is a one-cycle gap so the finished requester's cs can drop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r    <= IDLE;
         grant_id_r <= '0;
         last_r     <= GW'(NREQ - 1);
         m_reg_cs_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (found_s) begin
                  grant_id_r <= win_s;
                  m_reg_cs_r <= 1'b1;
                  state_r    <= BUSY;
               end
            end
            BUSY: begin
               if (m_reg_ack) begin
                  m_reg_cs_r <= 1'b0;
                  last_r     <= grant_id_r;
                  state_r    <= RELEASE;
               end
            end
            RELEASE: state_r <= IDLE;
            default: begin
               state_r    <= IDLE;
               m_reg_cs_r <= 1'b0;
            end
         endcase
      end
   end

   assign ack_hit_s    = (state_r == BUSY) & m_reg_ack;
   assign m_reg_addr_s = req_addr[int'(grant_id_r)*AW +: AW];

   // Zero-latency return path to the granted requester only.
   always_comb begin
      req_ack_s     = '0;
      req_timeout_s = '0;
      if (ack_hit_s) begin
         req_ack_s[grant_id_r]     = 1'b1;
         req_timeout_s[grant_id_r] = m_reg_timeout;
      end else begin
         req_ack_s     = '0;
         req_timeout_s = '0;
      end
   end

   assign req_ack     = req_ack_s;
   assign req_timeout = req_timeout_s;
   assign req_rdata   = m_reg_rdata;
   assign m_reg_cs    = m_reg_cs_r;
   assign m_reg_addr  = m_reg_addr_s;
   assign m_reg_wdata = req_wdata[int'(grant_id_r)*DW +: DW];
   assign m_reg_wr    = req_wr[grant_id_r];
   assign m_reg_be    = req_be[int'(grant_id_r)*BEW +: BEW];
   assign grant_id    = grant_id_r;

`ifdef REG_ARB_ERR_LOG_EN
   logic           err_valid_r;
   logic [GW-1:0]  err_id_r;
   logic [AW-1:0]  err_addr_r;

   // First timeout is kept until cleared; a capture beats a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_valid_r <= 1'b0;
         err_id_r    <= '0;
         err_addr_r  <= '0;
      end else if (ack_hit_s && m_reg_timeout) begin
         err_valid_r <= 1'b1;
         if (!err_valid_r) begin
            err_id_r   <= grant_id_r;
            err_addr_r <= m_reg_addr_s;
         end
      end else if (err_clr) begin
         err_valid_r <= 1'b0;
      end
   end

   assign err_valid = err_valid_r;
   assign err_id    = err_id_r;
   assign err_addr  = err_addr_r;
`else
   logic unused_err_clr_s;
   assign unused_err_clr_s = err_clr;
   assign err_valid = 1'b0;
   assign err_id    = '0;
   assign err_addr  = '0;
`endif

endmodule

// File: tb/tb_reg_bus_arb.sv
// Self-checking bench for reg_bus_arb: vector table, corner sequences, and
// randomized traffic against a transaction-level model.
module tb_reg_bus_arb;

   localparam int NREQ = 4;
   localparam int AW   = 26;
   localparam int DW   = 32;
   localparam int BEW  = 4;
   localparam int GW   = 2;
`ifdef REG_ARB_ERR_LOG_EN
   localparam bit LOG_EN = 1'b1;
`else
   localparam bit LOG_EN = 1'b0;
`endif

   logic                 clk;
   logic                 reset_n;
   logic [NREQ-1:0]      req_cs;
   logic [NREQ*AW-1:0]   req_addr;
   logic [NREQ*DW-1:0]   req_wdata;
   logic [NREQ-1:0]      req_wr;
   logic [NREQ*BEW-1:0]  req_be;
   logic [DW-1:0]        req_rdata;
   logic [NREQ-1:0]      req_ack;
   logic [NREQ-1:0]      req_timeout;
   logic                 m_reg_cs;
   logic [AW-1:0]        m_reg_addr;
   logic [DW-1:0]        m_reg_wdata;
   logic                 m_reg_wr;
   logic [BEW-1:0]       m_reg_be;
   logic [DW-1:0]        m_reg_rdata;
   logic                 m_reg_ack;
   logic                 m_reg_timeout;
   logic [GW-1:0]        grant_id;
   logic                 err_valid;
   logic [GW-1:0]        err_id;
   logic [AW-1:0]        err_addr;
   logic                 err_clr;

   logic [AW-1:0]  addr_a  [NREQ];
   logic [DW-1:0]  wdata_a [NREQ];
   logic           wr_a    [NREQ];
   logic [BEW-1:0] be_a    [NREQ];

   int checks = 0;
   int errors = 0;

   bit            err_v_m;
   logic [GW-1:0] err_id_m;
   logic [AW-1:0] err_addr_m;

   reg_bus_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .BEW(BEW)) dut (
      .clk(clk), .reset_n(reset_n), .req_cs(req_cs), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_wr(req_wr), .req_be(req_be),
      .req_rdata(req_rdata), .req_ack(req_ack), .req_timeout(req_timeout),
      .m_reg_cs(m_reg_cs), .m_reg_addr(m_reg_addr), .m_reg_wdata(m_reg_wdata),
      .m_reg_wr(m_reg_wr), .m_reg_be(m_reg_be), .m_reg_rdata(m_reg_rdata),
      .m_reg_ack(m_reg_ack), .m_reg_timeout(m_reg_timeout), .grant_id(grant_id),
      .err_valid(err_valid), .err_id(err_id), .err_addr(err_addr), .err_clr(err_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack per-requester transaction fields onto the flattened buses.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_addr[i*AW +: AW]    = addr_a[i];
         req_wdata[i*DW +: DW]   = wdata_a[i];
         req_wr[i]               = wr_a[i];
         req_be[i*BEW +: BEW]    = be_a[i];
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   task automatic refresh(input int i);
      addr_a[i]  = AW'($urandom);
      wdata_a[i] = $urandom;
      wr_a[i]    = 1'($urandom);
      be_a[i]    = BEW'($urandom);
   endtask

   // One full transaction starting from an IDLE drive point; returns at the next IDLE drive point.
   task automatic do_txn(input logic [3:0] mask, input logic [3:0] next_mask, input int lat,
                         input logic to, input logic [31:0] rd, input int exp_g,
                         input logic clr_on_ack);
      logic [3:0] oh;
      oh = 4'b0001 << exp_g;
      req_cs = mask;
      mid();
      chk("idle_cs", 64'(m_reg_cs), 64'(0));
      cyc(); mid();
      chk("grant_cs", 64'(m_reg_cs), 64'(1));
      chk("grant_id", 64'(grant_id), 64'(exp_g));
      chk("m_addr", 64'(m_reg_addr), 64'(addr_a[exp_g]));
      chk("m_wdata", 64'(m_reg_wdata), 64'(wdata_a[exp_g]));
      chk("m_wr", 64'(m_reg_wr), 64'(wr_a[exp_g]));
      chk("m_be", 64'(m_reg_be), 64'(be_a[exp_g]));
      for (int i = 1; i < lat; i++) begin
         cyc(); mid();
         chk("no_early_ack", 64'(req_ack), 64'(0));
      end
      cyc();
      m_reg_ack = 1'b1; m_reg_timeout = to; m_reg_rdata = rd; err_clr = clr_on_ack;
      mid();
      chk("req_ack", 64'(req_ack), 64'(oh));
      chk("req_timeout", 64'(req_timeout), to ? 64'(oh) : 64'(0));
      chk("req_rdata", 64'(req_rdata), 64'(rd));
      if (to && LOG_EN) begin
         if (!err_v_m) begin
            err_id_m   = GW'(exp_g);
            err_addr_m = addr_a[exp_g];
         end
         err_v_m = 1'b1;
      end else if (clr_on_ack) begin
         err_v_m = 1'b0;
      end
      cyc();
      m_reg_ack = 1'b0; m_reg_timeout = 1'b0; err_clr = 1'b0; req_cs = next_mask;
      mid();
      chk("release_cs", 64'(m_reg_cs), 64'(0));
      chk("release_ack", 64'(req_ack), 64'(0));
      chk("err_valid", 64'(err_valid), 64'(err_v_m));
      chk("err_id", 64'(err_id), 64'(err_id_m));
      chk("err_addr", 64'(err_addr), 64'(err_addr_m));
      cyc();
   endtask

   task automatic check_reset_vals();
      chk("rst_cs", 64'(m_reg_cs), 64'(0));
      chk("rst_ack", 64'(req_ack), 64'(0));
      chk("rst_to", 64'(req_timeout), 64'(0));
      chk("rst_gid", 64'(grant_id), 64'(0));
      chk("rst_errv", 64'(err_valid), 64'(0));
      chk("rst_errid", 64'(err_id), 64'(0));
      chk("rst_erraddr", 64'(err_addr), 64'(0));
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; req_cs = '0; m_reg_ack = 1'b0; m_reg_timeout = 1'b0; err_clr = 1'b0;
      err_v_m = 1'b0; err_id_m = '0; err_addr_m = '0;
      cyc(); cyc();
      reset_n = 1'b1;
   endtask

   typedef struct {
      logic [3:0]  mask;
      logic        to;
      logic [31:0] rd;
      int          lat;
      int          exp_g;
   } vec_t;

   vec_t vt [11];

   initial begin
      logic [3:0] pend, nxt, add, extra, bit_b;
      int best, bd, d, last_m, maxw;
      int waits [NREQ];

      reset_n = 1'b1; req_cs = '0; m_reg_rdata = '0; m_reg_ack = 1'b0;
      m_reg_timeout = 1'b0; err_clr = 1'b0;
      err_v_m = 1'b0; err_id_m = '0; err_addr_m = '0;
      for (int i = 0; i < NREQ; i++) begin
         addr_a[i] = '0; wdata_a[i] = '0; wr_a[i] = 1'b0; be_a[i] = '0; waits[i] = 0;
      end
      #1 reset_n = 1'b0;
      cyc(); cyc(); mid();
      check_reset_vals();
      chk("rst_maddr", 64'(m_reg_addr), 64'(0));
      chk("rst_mwdata", 64'(m_reg_wdata), 64'(0));
      chk("rst_rdata", 64'(req_rdata), 64'(0));
      cyc();
      reset_n = 1'b1;
      cyc(); mid();
      check_reset_vals();
      cyc();

      // Single read from requester 2.
      addr_a[2] = 26'h0000040;
      do_txn(4'b0100, 4'b0000, 4, 1'b0, 32'hDEADBEEF, 2, 1'b0);

      apply_reset();
      for (int i = 0; i < NREQ; i++) begin
         addr_a[i]  = 26'h0001000 + AW'(i * 16);
         wdata_a[i] = 32'hA5A50000 + 32'(i);
         wr_a[i]    = (i % 2) == 1;
         be_a[i]    = 4'hF >> i;
      end
      vt[0]  = '{4'b1111, 1'b0, 32'h11111111, 2, 0};
      vt[1]  = '{4'b1111, 1'b0, 32'h22222222, 1, 1};
      vt[2]  = '{4'b1111, 1'b0, 32'h33333333, 3, 2};
      vt[3]  = '{4'b1111, 1'b0, 32'h44444444, 2, 3};
      vt[4]  = '{4'b1111, 1'b0, 32'h55555555, 1, 0};
      vt[5]  = '{4'b1010, 1'b1, 32'h66666666, 2, 1};
      vt[6]  = '{4'b0001, 1'b0, 32'h77777777, 1, 0};
      vt[7]  = '{4'b1001, 1'b0, 32'h88888888, 2, 3};
      vt[8]  = '{4'b0110, 1'b0, 32'h99999999, 1, 1};
      vt[9]  = '{4'b0100, 1'b1, 32'hAAAAAAAA, 3, 2};
      vt[10] = '{4'b1000, 1'b0, 32'hBBBBBBBB, 1, 3};
      for (int n = 0; n < 11; n++)
         do_txn(vt[n].mask, 4'b0000, vt[n].lat, vt[n].to, vt[n].rd, vt[n].exp_g, 1'b0);

      // Stale cs from requester 0 during RELEASE while requester 3 arrives.
      do_txn(4'b0001, 4'b1001, 2, 1'b0, 32'h0BADF00D, 0, 1'b0);
      do_txn(4'b1000, 4'b0000, 1, 1'b0, 32'h12345678, 3, 1'b0);

      // Reset while waiting for ack, with an ack arriving as reset asserts.
      req_cs = 4'b0100;
      cyc(); cyc();
      reset_n = 1'b0; m_reg_ack = 1'b1;
      err_v_m = 1'b0; err_id_m = '0; err_addr_m = '0;
      mid();
      check_reset_vals();
      cyc();
      m_reg_ack = 1'b0; req_cs = 4'b1111;
      cyc();
      reset_n = 1'b1;
      do_txn(4'b1111, 4'b0000, 2, 1'b0, 32'hCAFEF00D, 0, 1'b0);

      // Capture versus clear in the same cycle, then a standalone clear.
      do_txn(4'b0010, 4'b0000, 2, 1'b1, 32'h00000001, 1, 1'b0);
      do_txn(4'b0100, 4'b0000, 1, 1'b1, 32'h00000002, 2, 1'b1);
      err_clr = 1'b1;
      cyc();
      err_clr = 1'b0;
      err_v_m = 1'b0;
      mid();
      chk("err_cleared", 64'(err_valid), 64'(err_v_m));
      cyc();

      // Randomized traffic against the round-robin distance model.
      last_m = 2;
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++) refresh(i);
      for (int n = 0; n < 60; n++) begin
         best = 0; bd = NREQ;
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i]) begin
               d = (i - last_m - 1 + 2 * NREQ) % NREQ;
               if (d < bd) begin bd = d; best = i; end
            end
         end
         bit_b = 4'b0001 << best;
         add = 4'($urandom_range(0, 15)) & ~bit_b & ~pend;
         for (int i = 0; i < NREQ; i++) if (add[i]) refresh(i);
         nxt = (pend & ~bit_b) | add;
         do_txn(pend, nxt, $urandom_range(1, 6), $urandom_range(0, 5) == 0, $urandom, best,
                $urandom_range(0, 9) == 0);
         maxw = 0;
         for (int i = 0; i < NREQ; i++) begin
            if (i == int'(grant_id)) waits[i] = 0;
            else if (pend[i]) waits[i]++;
            else waits[i] = 0;
            if (waits[i] > maxw) maxw = waits[i];
         end
         chk("fairness", 64'(maxw <= NREQ - 1), 64'(1));
         last_m = best;
         extra = 4'($urandom_range(0, 15)) & ~nxt;
         for (int i = 0; i < NREQ; i++) if (extra[i]) refresh(i);
         pend = nxt | extra;
         if (pend == 4'b0000) begin
            best = $urandom_range(0, 3);
            refresh(best);
            pend = 4'b0001 << best;
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_bus_arb.md
# reg_bus_arb

Round-robin arbiter sharing one register-bus initiator port among NREQ requesters in a single clock domain. It sits in front of the clock-domain-crossing register-bus bridge: it grants one requester at a time, drives that requester's transaction onto the shared master port, and routes ack/rdata/timeout back. At most one transaction is outstanding.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- AW, 26, address width
- DW, 32, data width
- BEW, 4, byte-enable width

Ports:
- clk  in  1  single clock for the whole block
- reset_n  in  1  asynchronous, active-low reset
- req_cs  in  NREQ  per-requester chip select; held until its ack
- req_addr  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW]
- req_wdata  in  NREQ*DW  flattened write data
- req_wr  in  NREQ  1 = write
- req_be  in  NREQ*BEW  flattened byte enables
- req_rdata  out  DW  read data, broadcast to all requesters
- req_ack  out  NREQ  one-hot ack pulse to the granted requester
- req_timeout  out  NREQ  timeout pulse to the granted requester, coincident with its ack
- m_reg_cs  out  1  master chip select
- m_reg_addr  out  AW  granted address
- m_reg_wdata  out  DW  granted write data
- m_reg_wr  out  1  granted write flag
- m_reg_be  out  BEW  granted byte enables
- m_reg_rdata  in  DW  master read data, valid with m_reg_ack
- m_reg_ack  in  1  master completion pulse
- m_reg_timeout  in  1  master timeout pulse, only valid with m_reg_ack
- grant_id  out  $clog2(NREQ)  index of the current or last granted requester
- err_valid  out  1  sticky timeout-logged flag
- err_id  out  $clog2(NREQ)  requester that timed out
- err_addr  out  AW  address that timed out
- err_clr  in  1  clears err_valid

## Operation
- FSM states: IDLE, BUSY, RELEASE. Reset puts the FSM in IDLE.
- IDLE: if any req_cs bit is set, pick the first set bit searching upward from (last+1) mod NREQ, with wrap-around. Register grant_id, set m_reg_cs=1, go to BUSY. If no bit is set, stay in IDLE.
- BUSY:
  - m_reg_addr/wdata/wr/be are muxed from requester grant_id.
  - Wait for m_reg_ack. On the ack cycle:
    - req_ack[grant_id]=m_reg_ack and req_timeout[grant_id]=m_reg_timeout, both combinational.
    - req_rdata=m_reg_rdata.
  - Next edge: m_reg_cs=0, last=grant_id, go to RELEASE.
- RELEASE: exactly one cycle. All req_cs bits are ignored. Go to IDLE. This guarantees the finished requester's cs has dropped before the next arbitration.
- Requester rule: deassert cs in the cycle after its ack. A cs dropped while BUSY is ignored; the transaction runs until m_reg_ack.
- The arbiter has no watchdog of its own. Hung targets are terminated by the downstream timeout, which arrives as m_reg_ack together with m_reg_timeout.
- m_reg_ack outside BUSY is ignored.
- Reset values:
  - m_reg_cs=0, req_ack=0, req_timeout=0, grant_id=0.
  - last=NREQ-1, so requester 0 wins first.
  - err_valid=0, err_id=0, err_addr=0.
  - req_rdata and m_reg_* data outputs follow the mux/broadcast path; they are 0 while all inputs are 0.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and in-flight acks are dropped.

## Timing
- Request latency: req_cs high in IDLE at cycle 0 gives m_reg_cs=1 at cycle 1.
- Ack path has zero added latency: m_reg_ack at cycle t gives req_ack at cycle t.
- Cycle t+1: m_reg_cs=0 (RELEASE). Cycle t+2: IDLE, and the next grant shows m_reg_cs=1 at t+3.
- Back-to-back throughput: one transaction per (master latency + 3) cycles.
- Fairness: every requester holding cs is granted within NREQ-1 other transactions.

## Configuration
- REG_ARB_ERR_LOG_EN defined:
  - On m_reg_ack with m_reg_timeout in BUSY, capture err_id=grant_id and err_addr=granted address, and set err_valid.
  - Once err_valid is set, later timeouts do not overwrite the log.
  - err_clr clears err_valid. If a capture and err_clr happen in the same cycle, the capture wins.
- REG_ARB_ERR_LOG_EN undefined: the err_* ports remain but are tied to 0, and err_clr is ignored.

## Structure
- Package reg_arb_pkg holds:
  - the FSM state enum (IDLE, BUSY, RELEASE);
  - the constant NREQ_MAX=8;
  - the function for grant-id width.
- Sub-module reg_arb_rr_pick: combinational round-robin picker. Inputs are the req vector and the last index; outputs are a found flag and the winner index.

## Test plan
- Single read: req_cs[2]=1 with addr 0x0000_40; master returns ack with rdata 0xDEAD_BEEF 5 cycles after cs. Expect m_reg_cs at cycle 1, req_ack=4'b0100 and req_rdata=0xDEADBEEF on the ack cycle, m_reg_cs=0 the next cycle.
- Round-robin: all four cs held after reset. Grant order must be 0,1,2,3,0; grant_id matches each m_reg_cs assertion.
- Timeout: requester 1 write; master acks with timeout=1. Expect req_timeout=4'b0010 with req_ack. With the macro, err_valid=1, err_id=1, err_addr latched. Without the macro, err_* stay 0.
- Stale cs: requester 0 keeps cs high one cycle after its ack, and requester 3 requests at the same time. Expect requester 0 not re-granted in RELEASE, and requester 3 granted next.
- Reset mid-BUSY: assert reset_n=0 while waiting for ack. Expect all outputs at reset values, and requester 0 wins first after release.
- Clear vs capture: with the macro, err_clr in the same cycle as a new timeout ack. Expect err_valid to remain 1.
